// File: rtl/mem_client_pkg.sv
// Shared types and helpers for the memory read/write client front-ends.
// Holds the request FSM encoding and the credit counter width helper.
package mem_client_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } rd_state_t;

  // A counter that must hold the value DEPTH itself needs clog2(DEPTH+1) bits.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_read_client_sync_fifo.sv
// Show-ahead synchronous FIFO (module sync_fifo); head is visible on dout while not empty.
// Full/empty come from the occupancy count; pointers wrap modulo FIFO_DEPTH.
module sync_fifo
  import mem_client_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 4,
  localparam int CW         = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(FIFO_DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign count     = r_count;
  assign dout      = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/mem_read_client.sv
// Per-requester read front-end: issues reads on one memory port and returns data in order.
// Optional MEM_READ_CLIENT_ERR_EN adds a sticky err output and protocol assertions.
module mem_read_client
  import mem_client_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int CW         = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  output logic                  mem_r_avalid,
  input  logic                  mem_r_aready,
  input  logic                  mem_r_dvalid,
  input  logic [DATA_WIDTH-1:0] mem_r_data
`ifdef MEM_READ_CLIENT_ERR_EN
  ,
  output logic                  err
`endif
);

  rd_state_t             r_state;
  rd_state_t             w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_avalid;
  logic                  r_req_ready;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         w_out_next;
  logic [CW-1:0]         w_fifo_count;
  logic [CW-1:0]         w_count_next;
  logic [DATA_WIDTH-1:0] w_dout;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_accept;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_credit_ok;

  assign w_accept = req_valid && r_req_ready;
  assign w_issue  = (r_state == ST_REQ) && mem_r_aready;
  assign w_pop    = rsp_ready && !w_empty;
  // Credit accounting means full never coincides with a tracked return; the guard is belt-and-braces.
  assign w_push   = mem_r_dvalid && (r_outstanding != '0) && (!w_full || w_pop);

  assign w_out_next   = r_outstanding + CW'(w_issue) - CW'(w_push);
  assign w_count_next = w_fifo_count + CW'(w_push) - CW'(w_pop);
  assign w_credit_ok  = ({1'b0, w_count_next} + {1'b0, w_out_next}) < (CW + 1)'(FIFO_DEPTH);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_REQ;
      ST_REQ:  if (mem_r_aready) w_state_next = ST_GAP;
      ST_GAP:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // req_ready is precomputed from next-cycle state and counters so it is a clean register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_avalid      <= 1'b0;
      r_req_ready   <= 1'b0;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_next;
      if (w_accept) r_addr <= req_addr;
      r_avalid      <= (w_state_next == ST_REQ);
      r_req_ready   <= (w_state_next == ST_IDLE) && w_credit_ok;
      r_outstanding <= w_out_next;
    end
  end

  assign req_ready    = r_req_ready;
  assign mem_r_avalid = r_avalid;
  assign mem_r_addr   = r_addr;
  assign rsp_valid    = !w_empty;
  assign rsp_data     = w_dout;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (mem_r_data),
    .dout  (w_dout),
    .count (w_fifo_count),
    .empty (w_empty),
    .full  (w_full)
  );

`ifdef MEM_READ_CLIENT_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((mem_r_dvalid && (r_outstanding == '0)) ||
                 (mem_r_aready && (r_state != ST_REQ))) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(mem_r_dvalid && (r_outstanding != '0) && w_full && !w_pop));

  a_addr_stable: assert property (@(posedge clk) disable iff (rst)
    ((r_state == ST_REQ) && !mem_r_aready) |=> $stable(mem_r_addr));
`endif

endmodule
